// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: source requests/words in, registered bus out.
// master = arbiter side, slave = sources and destinations.
interface bus_arbiter_if #(
  parameter int word_width = 16,
  parameter int n_src      = 4,
  parameter int n_dst      = 4
);
  logic [n_src-1:0]            src_req;
  logic [n_src-1:0]            src_lock;
  logic [n_src*word_width-1:0] src_data;
  logic [n_src*n_dst-1:0]      src_dst;
  logic [n_src-1:0]            src_gnt;
  logic [word_width-1:0]       bus_data;
  logic                        bus_valid;
  logic [n_dst-1:0]            dst_load;
  logic                        bus_err;

  modport master (
    input  src_req, src_lock, src_data, src_dst,
    output src_gnt, bus_data, bus_valid, dst_load, bus_err
  );

  modport slave (
    output src_req, src_lock, src_data, src_dst,
    input  src_gnt, bus_data, bus_valid, dst_load, bus_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin word bus arbiter with burst lock and sticky error.
// One registered transfer per cycle to a multi-hot destination set.
module bus_arbiter #(
  parameter int word_width = 16,
  parameter int n_src      = 4,
  parameter int n_dst      = 4,
  parameter int max_burst  = 4
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);
  localparam int sw = (n_src > 1) ? $clog2(n_src) : 1;
  localparam int bw = (max_burst > 1) ? $clog2(max_burst) : 1;

  logic [sw-1:0]         rr_ptr;
  logic [sw-1:0]         owner;
  logic                  owner_vld;
  logic [bw-1:0]         burst_cnt;
  logic [sw-1:0]         win_idx;
  logic [sw-1:0]         idx;
  logic                  win_vld;
  logic                  lock_hit;
  logic [word_width-1:0] win_data;
  logic [n_dst-1:0]      win_dst;

  // Pick this cycle's winner: locked owner first, else round-robin scan.
  always_comb begin
    idx      = '0;
    win_vld  = 1'b0;
    win_idx  = rr_ptr;
    lock_hit = owner_vld
             && bus.src_req[owner]
             && bus.src_lock[owner]
             && (int'(burst_cnt) < max_burst - 1);
    if (lock_hit) begin
      win_vld = 1'b1;
      win_idx = owner;
    end else begin
      for (int k = 1; k <= n_src; k++) begin
        idx = sw'((int'(rr_ptr) + k) % n_src);
        if (!win_vld && bus.src_req[idx]) begin
          win_vld = 1'b1;
          win_idx = idx;
        end
      end
    end
    win_data = bus.src_data[int'(win_idx)*word_width +: word_width];
    win_dst  = bus.src_dst[int'(win_idx)*n_dst +: n_dst];
  end

  // Register the transfer and advance pointer, burst and error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.src_gnt   <= '0;
      bus.bus_data  <= '0;
      bus.bus_valid <= 1'b0;
      bus.dst_load  <= '0;
      bus.bus_err   <= 1'b0;
      rr_ptr        <= sw'(n_src - 1);
      burst_cnt     <= '0;
      owner         <= '0;
      owner_vld     <= 1'b0;
    end else begin
      bus.bus_valid <= win_vld;
      owner_vld     <= win_vld;
      if (win_vld) begin
        bus.src_gnt  <= n_src'(1) << win_idx;
        bus.bus_data <= win_data;
        bus.dst_load <= win_dst;
        owner        <= win_idx;
        if (win_dst == '0) begin
          bus.bus_err <= 1'b1;
        end
        if (lock_hit) begin
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= '0;
          rr_ptr    <= win_idx;
        end
      end else begin
        bus.src_gnt  <= '0;
        bus.dst_load <= '0;
        burst_cnt    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: vector table, hand sequences, random vs model.
// Reference model tracks last winner, run length and rotation start.
module tb_bus_arbiter;
  localparam int WW = 16;
  localparam int NS = 4;
  localparam int ND = 4;
  localparam int MB = 4;

  logic clk;
  logic rst;
  logic [NS-1:0] req;
  logic [NS-1:0] lock;
  logic [WW-1:0] sd [NS];
  logic [ND-1:0] dd [NS];

  int total;
  int bad;

  bus_arbiter_if #(.word_width(WW), .n_src(NS), .n_dst(ND)) bus ();

  bus_arbiter #(
    .word_width(WW), .n_src(NS), .n_dst(ND), .max_burst(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.src_req  = req;
  assign bus.src_lock = lock;

  always_comb begin
    bus.src_data = '0;
    bus.src_dst  = '0;
    for (int i = 0; i < NS; i++) begin
      bus.src_data[i*WW +: WW] = sd[i];
      bus.src_dst[i*ND +: ND]  = dd[i];
    end
  end

  // reference model state
  int rr;
  int last_w;
  int run;
  logic [NS-1:0] m_gnt;
  logic [WW-1:0] m_data;
  logic [ND-1:0] m_load;
  logic m_valid;
  logic m_err;

  function automatic void model_reset();
    rr = NS - 1;
    last_w = -1;
    run = 0;
    m_gnt = '0;
    m_data = '0;
    m_load = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void model_step();
    int w;
    int c;
    bit locked;
    w = -1;
    locked = 1'b0;
    if (last_w >= 0 && req[last_w] && lock[last_w] && run < MB) begin
      w = last_w;
      locked = 1'b1;
    end else begin
      for (int k = 1; k <= NS; k++) begin
        c = (rr + k) % NS;
        if (w < 0 && req[c]) w = c;
      end
    end
    if (w < 0) begin
      m_gnt = '0;
      m_load = '0;
      m_valid = 1'b0;
      last_w = -1;
      run = 0;
    end else begin
      m_gnt = '0;
      m_gnt[w] = 1'b1;
      m_data = sd[w];
      m_load = dd[w];
      m_valid = 1'b1;
      if (dd[w] == '0) m_err = 1'b1;
      if (locked) begin
        run++;
      end else begin
        run = 1;
        rr = w;
      end
      last_w = w;
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model",
        {bus.src_gnt, bus.bus_data, bus.bus_valid, bus.dst_load, bus.bus_err},
        {m_gnt, m_data, m_valid, m_load, m_err});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("reset",
        {bus.src_gnt, bus.bus_data, bus.bus_valid, bus.dst_load, bus.bus_err},
        64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [NS-1:0] req;
    logic [NS-1:0] lock;
    logic [NS-1:0] gnt;
    logic          valid;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [NS-1:0] r, logic [NS-1:0] l,
                              logic [NS-1:0] g, logic v);
    vec_t e;
    e.req = r;
    e.lock = l;
    e.gnt = g;
    e.valid = v;
    tbl.push_back(e);
  endfunction

  function automatic void default_src();
    for (int i = 0; i < NS; i++) begin
      sd[i] = 16'hD000 + 16'(i);
      dd[i] = 4'(1 << i);
    end
  endfunction

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    req = '0;
    lock = '0;
    default_src();
    #2;

    // basic single transfer
    do_reset();
    sd[0] = 16'hA5A5;
    dd[0] = 4'b0110;
    req = 4'b0001;
    tick();
    chk("single", {bus.src_gnt, bus.bus_data, bus.dst_load, bus.bus_valid},
        {4'b0001, 16'hA5A5, 4'b0110, 1'b1});
    req = 4'b0000;
    tick();
    chk("single_idle", {bus.src_gnt, bus.bus_data, bus.dst_load, bus.bus_valid},
        {4'b0000, 16'hA5A5, 4'b0000, 1'b0});

    // table: rotation, burst lock, lone locked requester
    default_src();
    for (int i = 0; i < 8; i++) add(4'b1111, 4'b0000, 4'(1 << (i % 4)), 1'b1);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0100, 4'b0100, 4'b0100, 1'b1);
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 3; i++) add(4'b0101, 4'b0100, 4'b0100, 1'b1);
      add(4'b0101, 4'b0100, 4'b0001, 1'b1);
      if (j == 0) add(4'b0101, 4'b0100, 4'b0100, 1'b1);
    end
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) add(4'b0010, 4'b0010, 4'b0010, 1'b1);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      lock = tbl[i].lock;
      tick();
      chk($sformatf("vec%0d", i), {bus.src_gnt, bus.bus_valid, bus.dst_load},
          {tbl[i].gnt, tbl[i].valid, tbl[i].gnt});
    end

    // error: empty destination mask, sticky until reset
    do_reset();
    dd[3] = 4'b0000;
    req = 4'b1000;
    lock = 4'b0000;
    tick();
    chk("err_set", {bus.bus_valid, bus.dst_load, bus.bus_err},
        {1'b1, 4'b0000, 1'b1});
    dd[3] = 4'b1000;
    req = 4'b0001;
    tick();
    chk("err_sticky", {bus.src_gnt, bus.dst_load, bus.bus_err},
        {4'b0001, 4'b0001, 1'b1});
    req = 4'b0000;
    tick();
    chk("err_idle", {bus.bus_valid, bus.bus_err}, {1'b0, 1'b1});
    do_reset();
    chk("err_clear", {63'd0, bus.bus_err}, 64'd0);

    // async reset in the middle of a lock burst
    req = 4'b0100;
    lock = 4'b0100;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async",
        {bus.src_gnt, bus.bus_data, bus.bus_valid, bus.dst_load, bus.bus_err},
        64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1001;
    lock = 4'b0000;
    tick();
    chk("post_rst", {bus.src_gnt, bus.bus_valid}, {4'b0001, 1'b1});

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      req = 4'($urandom);
      lock = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      for (int i = 0; i < NS; i++) begin
        sd[i] = 16'($urandom);
        dd[i] = ($urandom_range(0, 63) == 0) ? 4'b0000
              : 4'($urandom_range(1, 15));
      end
      tick();
      total++;
      if ($countones(bus.src_gnt) > 1 || (bus.dst_load != 0 && !bus.bus_valid)) begin
        bad++;
        $display("FAIL onehot t=%0t gnt=%b load=%b valid=%b",
                 $time, bus.src_gnt, bus.dst_load, bus.bus_valid);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
